mem_port_arbiter: RTL

Arbiter that shares one single-port, fixed-latency synchronous memory between the pipeline's instruction-fetch port and data-memory (load/store) port. Sits between the fetch/memory stages of `riscv_pipeline` and the unified memory. Serialises accesses through a small FSM and a latency counter. Returns per-port `ready` pulses that the pipeline's hazard logic uses as stall-release.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/mem_lat_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: arbiter states, counter width and port ids.
// Imported by the memory-port arbiter and its latency timer.
package riscv_pkg;

  localparam int   ARB_CNT_W = 4;
  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DM   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } arb_state_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter tracking the fixed memory latency.
// done is high while the count sits at 1 (last wait cycle).
import riscv_pkg::*;

module mem_lat_timer #(
  parameter int W = ARB_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one fixed-latency single-port memory.
// Define ARB_ROUND_ROBIN_EN to alternate on simultaneous requests.
import riscv_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [ARB_CNT_W-1:0] LAT = ARB_CNT_W'(MEM_LAT);

  arb_state_t state;
  logic       grant;
  logic       pick_dm;
  logic       done;

  assign grant    = (state == IDLE) && (if_req || dm_req);
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Ties go to whichever port did not win last time.
  assign pick_dm = dm_req && (!if_req || (last_grant == PORT_IF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_IF;
    end else if (grant) begin
      last_grant <= pick_dm ? PORT_DM : PORT_IF;
    end
  end
`else
  assign pick_dm = dm_req;
`endif

  mem_lat_timer #(
    .W(ARB_CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (grant),
    .val  (LAT),
    .done (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            mem_en <= 1'b1;
            unique case (1'b1)
              pick_dm: begin
                state     <= BUSY_DM;
                mem_we    <= dm_we;
                mem_be    <= dm_be;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
              end
              default: begin
                state     <= BUSY_IF;
                mem_we    <= 1'b0;
                mem_be    <= '0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
              end
            endcase
          end
        end
        BUSY_IF, BUSY_DM: begin
          // The ready cycle is spent in BUSY so the next sample is one bubble later.
          if (if_ready || dm_ready) begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            state    <= IDLE;
          end else if (done) begin
            if_ready <= (state == BUSY_IF);
            dm_ready <= (state == BUSY_DM);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
